// File: rtl/eqcmp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// eqcmp_seq_ctrl
//
// Multi-word equality sequencer. On an accepted start it latches two wide
// operands (NWORDS slices of NBITS each) and walks them, one slice per cycle,
// through a single shared NBITS-wide XOR-reduce comparator. It reports
// whole-operand equality and the index of the lowest mismatching slice.
//
// Parameters:
//   NBITS   width of one slice and of the shared comparator
//   NWORDS  number of slices per operand (>= 2)
//   IDXW    slice index width (2**IDXW >= NWORDS)
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-high
//   start         in   request, only sampled while idle
//   a, b          in   operands, slice k = x[k*NBITS +: NBITS]
//   busy          out  high while comparing and during the done cycle
//   done          out  one-cycle pulse when the result is valid
//   equal         out  1 = all slices equal (valid from the done cycle)
//   mismatch_idx  out  lowest mismatching slice, 0 when equal
//
// Optional feature macro: EQCMP_EARLY_EXIT_EN
//   When defined, the scan stops at the first mismatching slice and goes
//   straight to the done cycle. When undefined, all NWORDS slices are always
//   scanned and the latency is fixed at NWORDS+1 cycles.
// ---------------------------------------------------------------------------

// Shared slice comparator: high when the two slices differ.
module eqcmp_slice_cmp #(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] i_a,
    input  logic [NBITS-1:0] i_b,
    output logic             o_ne
);
    assign o_ne = |(i_a ^ i_b);
endmodule

module eqcmp_seq_ctrl #(
    parameter int NBITS  = 16,
    parameter int NWORDS = 4,
    parameter int IDXW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NBITS*NWORDS-1:0] a,
    input  logic [NBITS*NWORDS-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic                    equal,
    output logic [IDXW-1:0]         mismatch_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    state_t                    r_state;
    logic [NBITS*NWORDS-1:0]   r_a;
    logic [NBITS*NWORDS-1:0]   r_b;
    logic [IDXW-1:0]           r_idx;
    logic                      r_flag;       // a mismatch has already been recorded
    logic                      r_busy;
    logic                      r_done;
    logic                      r_equal;
    logic [IDXW-1:0]           r_mis_idx;

    logic [NBITS-1:0]          w_a_words [NWORDS];
    logic [NBITS-1:0]          w_b_words [NWORDS];
    logic [NBITS-1:0]          w_a_slice;
    logic [NBITS-1:0]          w_b_slice;
    logic                      w_ne;
    logic                      w_first_ne;   // mismatch on this slice and none before it

    // Split the latched operands into addressable slices.
    for (genvar gk = 0; gk < NWORDS; gk++) begin : g_slice
        assign w_a_words[gk] = r_a[gk*NBITS +: NBITS];
        assign w_b_words[gk] = r_b[gk*NBITS +: NBITS];
    end

    assign w_a_slice  = w_a_words[r_idx];
    assign w_b_slice  = w_b_words[r_idx];
    assign w_first_ne = w_ne & ~r_flag;

    eqcmp_slice_cmp #(
        .NBITS (NBITS)
    ) u_cmp (
        .i_a  (w_a_slice),
        .i_b  (w_b_slice),
        .o_ne (w_ne)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_flag    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_equal   <= 1'b0;
            r_mis_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Operands are captured here only; later changes on a/b are ignored.
                        r_a       <= a;
                        r_b       <= b;
                        r_idx     <= '0;
                        r_flag    <= 1'b0;
                        r_equal   <= 1'b0;
                        r_mis_idx <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= S_CMP;
                    end
                end

                S_CMP: begin
                    if (w_first_ne) begin
                        r_mis_idx <= r_idx;
                        r_flag    <= 1'b1;
                    end
`ifdef EQCMP_EARLY_EXIT_EN
                    if (w_first_ne) begin
                        r_equal <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_idx == LAST_IDX) begin
                        r_equal <= ~r_flag;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
`else
                    if (r_idx == LAST_IDX) begin
                        // Fold in the last slice's result, which is not in r_flag yet.
                        r_equal <= ~(r_flag | w_ne);
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    // start is ignored here; it is accepted on the following idle cycle.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign equal        = r_equal;
    assign mismatch_idx = r_mis_idx;

endmodule

// File: tb/tb_eqcmp_seq_ctrl.sv
module tb_eqcmp_seq_ctrl;

    localparam bit EARLY =
`ifdef EQCMP_EARLY_EXIT_EN
        1'b1;
`else
        1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] a_in;
    logic [63:0] b_in;
    logic        busy;
    logic        done;
    logic        equal;
    logic [1:0]  mismatch_idx;

    int checks = 0;
    int errors = 0;

    // Result the bench expects to be held on the outputs between transactions.
    logic        exp_eq_q;
    logic [1:0]  exp_idx_q;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        eq;
        logic [1:0]  idx;
    } vec_t;

    vec_t vecs [8];

    eqcmp_seq_ctrl #(
        .NBITS  (16),
        .NWORDS (4),
        .IDXW   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a            (a_in),
        .b            (b_in),
        .busy         (busy),
        .done         (done),
        .equal        (equal),
        .mismatch_idx (mismatch_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycle of the done pulse, counting the start-accept cycle as 0.
    function automatic int lat(input logic eeq, input logic [1:0] eidx);
        return (EARLY && !eeq) ? int'(eidx) + 2 : 5;
    endfunction

    // Starts on the next falling edge (cycle 0) and checks every cycle up to
    // done + hold. Returns positioned on the falling edge of the last cycle.
    task automatic run_txn(input logic [63:0] va, input logic [63:0] vb,
                           input logic eeq, input logic [1:0] eidx,
                           input int hold, input string nm);
        int dc;
        dc = lat(eeq, eidx);
        @(negedge clk);
        check({nm, "_held_eq"}, equal, exp_eq_q);
        check({nm, "_held_idx"}, mismatch_idx, exp_idx_q);
        start = 1'b1;
        a_in  = va;
        b_in  = vb;
        for (int c = 1; c <= dc + hold; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                a_in  = ~va;      // must not affect the latched operands
                b_in  = va;
                check({nm, "_clr_eq"}, equal, 1'b0);
                check({nm, "_clr_idx"}, mismatch_idx, 2'd0);
            end
            check($sformatf("%s_busy_done_c%0d", nm, c), {busy, done},
                  {(c <= dc), (c == dc)});
            if (c >= dc) begin
                check($sformatf("%s_eq_c%0d", nm, c), equal, eeq);
                check($sformatf("%s_idx_c%0d", nm, c), mismatch_idx, eidx);
            end
        end
        exp_eq_q  = eeq;
        exp_idx_q = eidx;
    endtask

    initial begin
        int d1, d2, npulse;
        logic        eq1, eq2;
        logic [1:0]  idx1, idx2;
        logic [63:0] base;

        vecs[0] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd0};
        vecs[1] = '{64'h0000_0000_0000_0000, 64'h0001_0000_0002_0000, 1'b0, 2'd1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 2'd0};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5679_9ABC_DEF0, 1'b0, 2'd2};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 2'd3};
        vecs[5] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 2'd0};
        vecs[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 2'd0};
        vecs[7] = '{64'hDEAD_BEEF_0000_0000, 64'hDEAD_0000_0000_0000, 1'b0, 2'd2};

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        exp_eq_q  = 1'b0;
        exp_idx_q = 2'd0;

        // Power-on reset state
        @(negedge clk);
        check("rst_state", {busy, done, equal, mismatch_idx}, 5'b0);
        rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].idx, 2, $sformatf("vec%0d", i));

        // Asynchronous reset clears a held nonzero mismatch_idx immediately
        run_txn(vecs[1].a, vecs[1].b, 1'b0, 2'd1, 1, "pre_rst1");
        #1 rst = 1'b1;
        #1 check("async_rst_idx", {busy, done, equal, mismatch_idx}, 5'b0);
        rst = 1'b0;
        exp_eq_q  = 1'b0;
        exp_idx_q = 2'd0;

        // Asynchronous reset in the done cycle, with busy/done/equal all high
        run_txn(vecs[0].a, vecs[0].b, 1'b1, 2'd0, 0, "pre_rst2");
        #2 rst = 1'b1;
        #1 check("async_rst_done", {busy, done, equal, mismatch_idx}, 5'b0);
        rst = 1'b0;
        exp_eq_q  = 1'b0;
        exp_idx_q = 2'd0;

        // start held high cycles 0..6 while a changes every cycle
        base   = 64'h0123_4567_89AB_CDEF;
        d1     = -1;
        d2     = -1;
        npulse = 0;
        eq1 = 1'b0; eq2 = 1'b0; idx1 = 2'd0; idx2 = 2'd0;
        @(negedge clk);
        b_in = base;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c > 0 && done) begin
                npulse++;
                if (d1 < 0) begin
                    d1 = c; eq1 = equal; idx1 = mismatch_idx;
                end else if (d2 < 0) begin
                    d2 = c; eq2 = equal; idx2 = mismatch_idx;
                end
            end
            if (c == 0)      begin start = 1'b1; a_in = base; end
            else if (c < 6)  begin start = 1'b1; a_in = base ^ (64'h1 << (c * 8 + 3)); end
            else if (c == 6) begin start = 1'b1; a_in = base ^ 64'h0000_0010_0000_0000; end
            else             begin start = 1'b0; a_in = base; end
        end
        check("hold_npulse", npulse, 2);
        check("hold_done1_cyc", d1, 5);
        check("hold_done2_cyc", d2, 6 + lat(1'b0, 2'd2));
        check("hold_eq1", eq1, 1'b1);
        check("hold_idx1", idx1, 2'd0);
        check("hold_eq2", eq2, 1'b0);
        check("hold_idx2", idx2, 2'd2);
        exp_eq_q  = 1'b0;
        exp_idx_q = 2'd2;

        // Reset in the middle of a compare: no done pulse follows
        npulse = 0;
        @(negedge clk);
        start = 1'b1; a_in = 64'h1; b_in = 64'h2;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midop_busy_before", busy, 1'b1);
        rst = 1'b1;
        #1 check("midop_busy_rst", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 4; c <= 12; c++) begin
            @(negedge clk);
            if (done) npulse++;
        end
        check("midop_no_done", npulse, 0);
        exp_eq_q  = 1'b0;
        exp_idx_q = 2'd0;
        run_txn(64'h0, 64'h0, 1'b1, 2'd0, 1, "after_rst");

        // Slice-0 mismatch followed immediately by a matching transaction
        run_txn(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_0000, 1'b0, 2'd0, 0, "b2b_first");
        run_txn(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 2'd0, 1, "b2b_second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
